weight_stream_reader: RTL and testbench

WEIGHT_STREAM_READER -- requirements
Module: weight_stream_reader

---
 rtl/weight_stream_reader_pkg.sv | 15 +
 rtl/weight_skid_fifo.sv | 63 ++++++
 rtl/weight_stream_reader.sv | 127 ++++++++++++
 tb/tb_weight_stream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_reader_pkg.sv
// Shared definitions for the weight stream reader: parameter defaults and
// the sweep controller state encoding.
package weight_stream_reader_pkg;

   localparam int unsigned DEPTH_DEF  = 28;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } wsr_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry output FIFO holding captured weight words plus their LAST flag.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (flushes contents)
//   push_i/data_i  write one entry on the rising edge
//   pop_i          remove the head entry (only asserted while valid_o=1)
//   data_o/valid_o head entry and non-empty flag
//   count_o        current occupancy (0..2)
module weight_skid_fifo
   import weight_stream_reader_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W_DEF + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;

   // Occupancy update; simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointers; reset zeroes entries so the head reads as 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/weight_stream_reader.sv
// Sweeps a weight memory from address 0 to DEPTH-1 on START and streams the
// words out through a valid/ready interface with backpressure.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   START                 one-cycle sweep request (ignored while BUSY)
//   BRAM_ADDR/EN/WE       weight-memory read port (WE tied low)
//   BRAM_DO               read data, valid at the end of the issuing cycle
//   W_DATA/W_VALID/W_LAST streamed word, valid flag, last-word flag
//   W_READY               consumer acceptance
//   BUSY                  sweep in progress
//   DONE                  one-cycle pulse after the final handshake
module weight_stream_reader
   import weight_stream_reader_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   input  logic [DATA_W-1:0] BRAM_DO,
   output logic [DATA_W-1:0] W_DATA,
   output logic              W_VALID,
   input  logic              W_READY,
   output logic              W_LAST,
   output logic              BUSY,
   output logic              DONE
);

   localparam int unsigned FW = DATA_W + 1;

   wsr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [FW-1:0]     head;
   logic              head_valid;
   logic [1:0]        occ;
   logic              pop;
   logic              issue;
   logic              last_addr;

   assign pop       = head_valid & W_READY;
   assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
   // Read data lands in the FIFO at the end of the issuing cycle, so a read
   // is safe whenever a slot is free or the head leaves this cycle.
   assign issue     = (state_q == ST_FETCH) && ((occ < 2'd2) || pop);

   weight_skid_fifo #(
      .WIDTH (FW)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (issue),
      .data_i  ({last_addr, BRAM_DO}),
      .pop_i   (pop),
      .data_o  (head),
      .valid_o (head_valid),
      .count_o (occ)
   );

   // Sweep controller next-state logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               if (last_addr) begin
                  state_d = ST_DRAIN;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head[DATA_W]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Controller state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BRAM_ADDR = addr_q;
   assign BRAM_EN   = issue;
   assign BRAM_WE   = 1'b0;
   assign W_DATA    = head[DATA_W-1:0];
   assign W_VALID   = head_valid;
   assign W_LAST    = head_valid & head[DATA_W];
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Bench for weight_stream_reader: memory model, ready-pattern driver, a
// negedge monitor feeding a word queue, and sweep scenarios checked against
// the expected address-ordered memory contents.
module tb_weight_stream_reader;
   import weight_stream_reader_pkg::*;

   localparam int unsigned DEPTH  = DEPTH_DEF;
   localparam int unsigned ADDR_W = ADDR_W_DEF;
   localparam int unsigned DATA_W = DATA_W_DEF;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              START = 1'b0;
   logic              W_READY = 1'b1;
   logic [DATA_W-1:0] BRAM_DO = '0;
   logic [ADDR_W-1:0] BRAM_ADDR;
   logic              BRAM_EN, BRAM_WE;
   logic [DATA_W-1:0] W_DATA;
   logic              W_VALID, W_LAST, BUSY, DONE;

   weight_stream_reader #(
      .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W)
   ) dut (
      .CLK (CLK), .RST (RST), .START (START),
      .BRAM_ADDR (BRAM_ADDR), .BRAM_EN (BRAM_EN), .BRAM_WE (BRAM_WE),
      .BRAM_DO (BRAM_DO), .W_DATA (W_DATA), .W_VALID (W_VALID),
      .W_READY (W_READY), .W_LAST (W_LAST), .BUSY (BUSY), .DONE (DONE)
   );

   always #5 CLK = ~CLK;

   // Weight memory: read data appears on the falling edge while EN is high.
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always @(negedge CLK) if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Ready patterns: 0 always, 1 stall for sweep cycles 5..14, 2 toggle, 3 random.
   int rdy_mode = 0;
   int t0 = 0;
   always @(posedge CLK) begin
      #1;
      case (rdy_mode)
         0: W_READY = 1'b1;
         1: W_READY = !(((cyc - t0) >= 5) && ((cyc - t0) <= 14));
         2: W_READY = ((cyc % 2) == 0);
         default: W_READY = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor state.
   logic [DATA_W-1:0] got_q[$];
   int last_cnt, last_pos, done_cnt, issued, accepted, max_occ, stab_err, we_err;
   int first_en, last_en, first_v, last_v, last_cyc, done_cyc, stall_en, busy_cnt;
   logic prev_stall = 1'b0;
   logic [DATA_W-1:0] pd;
   logic pl;

   task automatic clear_mon();
      got_q.delete();
      last_cnt = 0; last_pos = -1; done_cnt = 0; issued = 0; accepted = 0;
      max_occ = 0; stab_err = 0; we_err = 0; stall_en = 0; busy_cnt = 0;
      first_en = -1; last_en = -1; first_v = -1; last_v = -1;
      last_cyc = -1; done_cyc = -1;
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         prev_stall = 1'b0;
      end else begin
         if ((issued - accepted) > max_occ) max_occ = issued - accepted;
         if (prev_stall && (!W_VALID || W_DATA !== pd || W_LAST !== pl)) stab_err++;
         if (BRAM_WE !== 1'b0) we_err++;
         if (BUSY) busy_cnt++;
         if (BRAM_EN) begin
            issued++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (rdy_mode == 1 && (cyc - t0) >= 7 && (cyc - t0) <= 14) stall_en++;
         end
         if (W_VALID) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (W_VALID && W_READY) begin
            got_q.push_back(W_DATA);
            accepted++;
            if (W_LAST) begin
               last_cnt++;
               last_cyc = cyc;
               last_pos = got_q.size();
            end
         end
         if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = W_VALID && !W_READY;
         pd = W_DATA;
         pl = W_LAST;
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, " addr"},   64'(BRAM_ADDR), 0);
      chk({tag, " en"},     64'(BRAM_EN), 0);
      chk({tag, " we"},     64'(BRAM_WE), 0);
      chk({tag, " valid"},  64'(W_VALID), 0);
      chk({tag, " last"},   64'(W_LAST), 0);
      chk({tag, " data"},   64'(W_DATA), 0);
      chk({tag, " busy"},   64'(BUSY), 0);
      chk({tag, " done"},   64'(DONE), 0);
   endtask

   // One sweep: START pulse, optional extra START once restart_word words are in.
   task automatic run_sweep(input int mode, input int restart_word);
      bit pulsed = 1'b0;
      int n = 0;
      clear_mon();
      rdy_mode = mode;
      @(posedge CLK); #1;
      t0 = cyc;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      while (done_cnt == 0 && n < 600) begin
         if (restart_word >= 0 && !pulsed && got_q.size() >= restart_word) begin
            START = 1'b1;
            pulsed = 1'b1;
         end
         @(posedge CLK); #1;
         START = 1'b0;
         n++;
      end
      if (done_cnt == 0) chk("sweep timeout", 0, 1);
      repeat (4) @(posedge CLK);
      #1;
   endtask

   // Reference: words are the memory contents in address order, repeated per sweep.
   task automatic check_sweep(input string tag, input int nw, input int nl, input int nd);
      chk({tag, " words"}, 64'(got_q.size()), 64'(nw));
      for (int i = 0; i < got_q.size() && i < nw; i++)
         chk($sformatf("%s word%0d", tag, i), 64'(got_q[i]), 64'(mem[i % DEPTH]));
      chk({tag, " last count"}, 64'(last_cnt), 64'(nl));
      chk({tag, " last position"}, 64'(last_pos), 64'(nw));
      chk({tag, " done count"}, 64'(done_cnt), 64'(nd));
      chk({tag, " stall stability"}, 64'(stab_err), 0);
      chk({tag, " occupancy over 2"}, 64'(max_occ > 2), 0);
      chk({tag, " write enable"}, 64'(we_err), 0);
      chk({tag, " busy after"}, 64'(BUSY), 0);
   endtask

   typedef struct {
      int mode;
      int restart;
      int exp_words;
      int exp_last;
      int exp_done;
      bit timing;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      vecs[0] = '{0, -1, 28, 1, 1, 1'b1};
      vecs[1] = '{1, -1, 28, 1, 1, 1'b0};
      vecs[2] = '{2, -1, 28, 1, 1, 1'b0};
      vecs[3] = '{3, -1, 28, 1, 1, 1'b0};
      vecs[4] = '{0, 10, 28, 1, 1, 1'b0};
      vecs[5] = '{3, 10, 28, 1, 1, 1'b0};
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
      clear_mon();

      // Reset state, with START held high to show reset wins.
      RST = 1'b1;
      START = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_vals("reset");
      START = 1'b0;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Table-driven sweeps.
      for (int v = 0; v < 6; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         run_sweep(vecs[v].mode, vecs[v].restart);
         check_sweep(tag, vecs[v].exp_words, vecs[v].exp_last, vecs[v].exp_done);
         if (vecs[v].timing) begin
            chk({tag, " first en"}, 64'(first_en), 64'(t0 + 1));
            chk({tag, " last en"},  64'(last_en),  64'(t0 + 28));
            chk({tag, " en cycles"}, 64'(issued),  64'(28));
            chk({tag, " first valid"}, 64'(first_v), 64'(t0 + 2));
            chk({tag, " last valid"},  64'(last_v),  64'(t0 + 29));
            chk({tag, " last cycle"},  64'(last_cyc), 64'(t0 + 29));
            chk({tag, " done cycle"},  64'(done_cyc), 64'(t0 + 30));
            chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(29));
         end
         if (vecs[v].mode == 1) chk({tag, " en during stall"}, 64'(stall_en), 0);
      end

      // Reset in the middle of a sweep, then a clean restart from address 0.
      clear_mon();
      rdy_mode = 0;
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      n = 0;
      while (got_q.size() < 12 && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("mid reset reached word 12", 64'(got_q.size() >= 12), 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      check_reset_vals("mid reset");
      RST = 1'b0;
      @(posedge CLK); #1;
      run_sweep(0, -1);
      check_sweep("after reset", 28, 1, 1);

      // Back-to-back sweeps: second START on the DONE cycle.
      clear_mon();
      rdy_mode = 0;
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      n = 0;
      while (!DONE && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("b2b first done seen", 64'(DONE), 1);
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      n = 0;
      while (done_cnt < 2 && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      repeat (4) @(posedge CLK);
      #1;
      check_sweep("b2b", 56, 2, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
